fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Instruction-fetch sequencer that owns the program counter and drives it through an instruction-memory request/response interface. Hands fetched instructions to decode over a valid/ready handshake. Applies control-flow redirects (branch/jump targets from the ALU) and discards stale in-flight fetches. Sits between the imem port and the decode stage; it replaces the free-running PC register with a handshake-aware one.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0)
TIMEOUT, 64, max cycles in WAIT before fetch_err is raised (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (asserted when 0)
halt  in  1  blocks issue of new fetch requests while high
redirect_valid  in  1  redirect the PC this cycle
redirect_pc  in  32  redirect target
req_valid  out  1  imem request valid
req_addr  out  32  imem request address
req_ready  in  1  imem accepts request
rsp_valid  in  1  imem response valid (one per accepted request, any latency >=1)
rsp_data  in  32  imem response instruction word
inst_valid  out  1  instruction valid to decode
inst_data  out  32  instruction word
inst_pc  out  32  PC of inst_data
inst_pc_plus4  out  32  inst_pc + 4, mod 2^32
inst_ready  in  1  decode accepts instruction
fetch_err  out  1  sticky imem timeout flag
busy  out  1  state != IDLE

Behaviour:
- Reset (rst=0, async): pc=RESET_PC, state=IDLE, kill=0, timer=0, fetch_err=0; all outputs 0 except req_addr=RESET_PC.
- States: IDLE, REQ, WAIT, HOLD. Exactly one outstanding imem request at a time.
- IDLE: halt=0 -> REQ next cycle. halt=1 -> stay in IDLE.
- REQ: req_valid=1, req_addr=pc. req_addr changes while req_valid=1 only on a redirect. req_valid & req_ready -> WAIT.
- WAIT: timer increments each cycle. On rsp_valid:
  - kill=1: drop the data, clear kill, go REQ (IDLE if halt).
  - kill=0: latch inst_data=rsp_data, inst_pc=pc, set pc=pc+4 (wraps mod 2^32), go HOLD.
- HOLD: inst_valid=1 with inst_data/inst_pc stable until the handshake. On inst_ready: go REQ (IDLE if halt). Latency from request acceptance to inst_valid is 1 cycle after rsp_valid.
- Redirect: redirect_pc[1:0] is forced to 0. Redirect takes priority over the normal next-PC in every state.
  - IDLE: pc=redirect_pc, stay in IDLE (or go REQ per halt).
  - REQ, no req_ready this cycle: pc=redirect_pc, stay in REQ (new req_addr next cycle).
  - REQ with req_ready this cycle: the accepted request is stale. Go WAIT with kill=1, pc=redirect_pc.
  - WAIT, no rsp_valid: kill=1, pc=redirect_pc.
  - WAIT with rsp_valid same cycle: drop the response, pc=redirect_pc, go REQ.
  - HOLD: inst_valid drops next cycle, pc=redirect_pc, go REQ. If inst_ready is also high that cycle, the handshake counts as completed (instruction consumed) and the redirect still applies.
  - Back-to-back redirects: the last one wins. Only one kill is pending at any time, because only one request is ever outstanding.
- Timeout: timer clears on entry to WAIT. When timer reaches TIMEOUT, fetch_err is set and stays set until reset. The FSM remains in WAIT and still accepts a late response.
- halt: only gates entry into REQ. It never withdraws an asserted req_valid and never drops a held instruction.
- Reset mid-operation: immediate return to the reset state. Any in-flight imem response after reset release is not tracked; the imem side is reset together with this block.

Decomposition:
- Package fetch_pkg: state enum fetch_state_t (IDLE, REQ, WAIT, HOLD); constants INST_BYTES=4 and PC_ALIGN_MASK=32'hFFFF_FFFC; default RESET_PC.
- Sub-module fetch_timer: cycle counter of width $clog2(TIMEOUT+1), with clear/enable inputs and a sticky expired output.
- Everything else lives in fetch_ctrl using the team's DFF macros. Use the async active-low reset variant for all state.

Test Plan:
- Reset release, halt=0, req_ready=1, 1-cycle imem, inst_ready=1 -> req_addr sequence 0x0, 0x4, 0x8; inst_pc 0x0/0x4/0x8 with matching rsp_data; inst_pc_plus4 = 0x4/0x8/0xC.
- req_ready low 3 cycles at addr 0x10 -> req_valid and req_addr=0x10 held stable; pc unchanged; accepted on cycle 4.
- Redirect to 0x203 while in WAIT for 0x8, response arrives 2 cycles later -> response dropped, no inst_valid; next req_addr=0x200.
- Redirect 0x400 in HOLD with inst_ready=0 -> inst_valid falls next cycle; next req_addr=0x400; next inst_pc=0x400.
- Redirect same cycle as req_ready (addr 0x20, target 0x80) -> WAIT with kill; 0x20 data discarded; next request 0x80.
- TIMEOUT=4, rsp_valid withheld -> fetch_err=1 after 4 WAIT cycles; late response at cycle 7 delivered; fetch_err remains 1 until rst=0; pc=0xFFFF_FFFC fetch -> next pc 0x0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } fetch_state_t;

   localparam int unsigned INST_BYTES       = 4;
   localparam logic [31:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // Instructions are word aligned; low address bits are never issued.
   function automatic logic [31:0] align_pc(input logic [31:0] pc);
      return pc & PC_ALIGN_MASK;
   endfunction

endpackage

// File: rtl/fetch_timer.sv
// Response-latency watchdog: counts cycles spent waiting on imem and raises
// a sticky flag once the count reaches TIMEOUT. The count saturates so a very
// late response never wraps the counter back below the limit.
module fetch_timer #(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned W     = $clog2(TIMEOUT + 1);
   localparam logic [W-1:0] LIMIT = W'(TIMEOUT);
   localparam logic [W-1:0] LAST  = W'(TIMEOUT - 1);

   logic [W-1:0] count;

   // Saturating up-counter, restarted whenever a new wait begins.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != LIMIT)) begin
         count <= count + W'(1);
      end
   end

   // Sticky flag set on the same edge the count reaches the limit; only reset clears it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         expired <= 1'b0;
      end else if (enable && !clear && (count == LAST)) begin
         expired <= 1'b1;
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one imem request at a
// time, hands fetched words to decode and applies control-flow redirects.
//
// state | meaning
// IDLE  | no request outstanding; waits for halt to drop
// REQ   | request presented to imem, waiting for req_ready
// WAIT  | request accepted, waiting for rsp_valid (kill drops the data)
// HOLD  | instruction presented to decode, waiting for inst_ready
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int unsigned TIMEOUT  = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        halt,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        req_valid,
   output logic [31:0] req_addr,
   input  logic        req_ready,
   input  logic        rsp_valid,
   input  logic [31:0] rsp_data,
   output logic        inst_valid,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc,
   output logic [31:0] inst_pc_plus4,
   input  logic        inst_ready,
   output logic        fetch_err,
   output logic        busy
);

   fetch_state_t state, state_nxt, resume_state;

   logic [31:0] pc, pc_nxt, pc_inc;
   logic        kill, kill_nxt;
   logic        load_inst;
   logic        timer_clear, timer_en;

   logic [31:0] inst_data_q, inst_pc_q, inst_pc_plus4_q;

   assign pc_inc = pc + 32'(INST_BYTES);

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state, next PC and kill tracking; a redirect overrides the PC in every state.
   always_comb begin
      state_nxt    = state;
      pc_nxt       = pc;
      kill_nxt     = kill;
      load_inst    = 1'b0;
      resume_state = halt ? IDLE : REQ;
      unique case (state)
         IDLE: begin
            state_nxt = resume_state;
         end
         REQ: begin
            if (req_ready) begin
               state_nxt = WAIT;
               // The request just accepted targets the old PC.
               kill_nxt  = redirect_valid;
            end
         end
         WAIT: begin
            if (rsp_valid) begin
               kill_nxt  = 1'b0;
               state_nxt = resume_state;
               if (!kill && !redirect_valid) begin
                  load_inst = 1'b1;
                  pc_nxt    = pc_inc;
                  state_nxt = HOLD;
               end
            end else if (redirect_valid) begin
               kill_nxt = 1'b1;
            end
         end
         HOLD: begin
            if (redirect_valid || inst_ready) begin
               state_nxt = resume_state;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
      if (redirect_valid) begin
         pc_nxt = align_pc(redirect_pc);
      end
   end

   // Outputs decoded from the current state.
   always_comb begin
      req_valid  = (state == REQ);
      inst_valid = (state == HOLD);
      busy       = (state != IDLE);
   end

   // Program counter and stale-response marker.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc   <= align_pc(RESET_PC);
         kill <= 1'b0;
      end else begin
         pc   <= pc_nxt;
         kill <= kill_nxt;
      end
   end

   // Instruction holding register, loaded only by a live response.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         inst_data_q     <= '0;
         inst_pc_q       <= '0;
         inst_pc_plus4_q <= '0;
      end else if (load_inst) begin
         inst_data_q     <= rsp_data;
         inst_pc_q       <= pc;
         inst_pc_plus4_q <= pc_inc;
      end
   end

   assign req_addr      = pc;
   assign inst_data     = inst_data_q;
   assign inst_pc       = inst_pc_q;
   assign inst_pc_plus4 = inst_pc_plus4_q;

   assign timer_clear = (state == REQ) && req_ready;
   assign timer_en    = (state == WAIT);

   fetch_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (timer_clear),
      .enable  (timer_en),
      .expired (fetch_err)
   );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: a behavioural imem answers every accepted request
// after a programmable latency; delivered instructions are checked against
// a queue of expected {pc, data} pairs.
module tb_fetch_ctrl;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        halt;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        req_valid;
   logic [31:0] req_addr;
   logic        req_ready;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        inst_valid;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic [31:0] inst_pc_plus4;
   logic        inst_ready;
   logic        fetch_err;
   logic        busy;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   lat      = 1;
   exp_t sb_q[$];
   exp_t mon_e;
   bit   ok;
   bit   bad;

   fetch_ctrl #(
      .RESET_PC (32'h0000_0000),
      .TIMEOUT  (4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .halt           (halt),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .req_valid      (req_valid),
      .req_addr       (req_addr),
      .req_ready      (req_ready),
      .rsp_valid      (rsp_valid),
      .rsp_data       (rsp_data),
      .inst_valid     (inst_valid),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc),
      .inst_pc_plus4  (inst_pc_plus4),
      .inst_ready     (inst_ready),
      .fetch_err      (fetch_err),
      .busy           (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] imem_word(input logic [31:0] a);
      return a ^ 32'h5A5A_0F0F;
   endfunction

   function automatic exp_t mk(input logic [31:0] a);
      exp_t e;
      e.pc   = a;
      e.data = imem_word(a);
      return e;
   endfunction

   // imem model: one response per accepted request, lat cycles after acceptance.
   initial begin : imem_model
      bit          acc;
      bit          pend;
      int          cnt;
      logic [31:0] acc_addr;
      logic [31:0] paddr;
      rsp_valid = 1'b0;
      rsp_data  = '0;
      pend      = 1'b0;
      cnt       = 0;
      paddr     = '0;
      forever begin
         @(negedge clk);
         acc      = rst && req_valid && req_ready;
         acc_addr = req_addr;
         @(posedge clk);
         #1;
         if (!rst) begin
            pend      = 1'b0;
            rsp_valid = 1'b0;
         end else begin
            if (rsp_valid) rsp_valid = 1'b0;
            if (acc) begin
               pend  = 1'b1;
               cnt   = lat;
               paddr = acc_addr;
            end
            if (pend) begin
               cnt = cnt - 1;
               if (cnt <= 0) begin
                  rsp_valid = 1'b1;
                  rsp_data  = imem_word(paddr);
                  pend      = 1'b0;
               end
            end
         end
      end
   end

   // Scoreboard: each decode handshake must match the oldest expected instruction.
   always @(negedge clk) begin
      if (rst && inst_valid && inst_ready) begin
         n_checks++;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: got pc=%h data=%h, expected no instruction", inst_pc, inst_data);
         end else begin
            mon_e = sb_q.pop_front();
            if (inst_pc !== mon_e.pc || inst_data !== mon_e.data || inst_pc_plus4 !== mon_e.pc + 32'd4) begin
               n_fail++;
               $display("FAIL sb_inst: got pc=%h data=%h pc4=%h, expected pc=%h data=%h pc4=%h",
                        inst_pc, inst_data, inst_pc_plus4, mon_e.pc, mon_e.data, mon_e.pc + 32'd4);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req(input int max, output bit found);
      found = 1'b0;
      for (int i = 0; i < max; i++) begin
         if (req_valid) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      if (req_valid) found = 1'b1;
   endtask

   task automatic wait_idle(input int max, output bit found);
      found = 1'b0;
      for (int i = 0; i < max; i++) begin
         if (!busy) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      if (!busy) found = 1'b1;
   endtask

   task automatic redirect_idle(input logic [31:0] target);
      redirect_valid = 1'b1;
      redirect_pc    = target;
      tick();
      redirect_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; halt = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
      req_ready = 1'b1; inst_ready = 1'b1; lat = 1;
      tick(); tick();
      n_checks++;
      if ({req_valid, inst_valid, fetch_err, busy} !== 4'b0000) begin
         n_fail++; $display("FAIL reset_flags: got %b expected 0000", {req_valid, inst_valid, fetch_err, busy});
      end
      n_checks++;
      if (req_addr !== 32'h0) begin
         n_fail++; $display("FAIL reset_req_addr: got %h expected 00000000", req_addr);
      end
      n_checks++;
      if ({inst_data, inst_pc, inst_pc_plus4} !== 96'h0) begin
         n_fail++; $display("FAIL reset_inst: got %h %h %h expected zeros", inst_data, inst_pc, inst_pc_plus4);
      end
      rst = 1'b1;
      tick(); tick();
      n_checks++;
      if (busy !== 1'b0 || req_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_halt_idle: got busy=%b req_valid=%b expected 0 0", busy, req_valid);
      end
   endtask

   task automatic test_sequential();
      for (int i = 0; i < 3; i++) sb_q.push_back(mk(32'(4 * i)));
      halt = 1'b0;
      for (int i = 0; i < 3; i++) begin
         wait_req(10, ok);
         n_checks++;
         if (!ok || req_addr !== 32'(4 * i)) begin
            n_fail++; $display("FAIL seq_req_addr: got %h (found=%0d) expected %h", req_addr, ok, 32'(4 * i));
         end
         if (i == 2) halt = 1'b1;
         tick();
         tick();
         n_checks++;
         if (inst_valid !== 1'b1) begin
            n_fail++; $display("FAIL seq_latency: got inst_valid=%b expected 1", inst_valid);
         end
      end
      wait_idle(20, ok);
      n_checks++;
      if (!ok || sb_q.size() != 0) begin
         n_fail++; $display("FAIL seq_drain: got idle=%0d pending=%0d expected 1 0", ok, sb_q.size());
      end
   endtask

   task automatic test_req_stall();
      redirect_idle(32'h0000_0013);
      n_checks++;
      if (req_valid !== 1'b0 || req_addr !== 32'h10) begin
         n_fail++; $display("FAIL stall_idle_redirect: got v=%b addr=%h expected 0 00000010", req_valid, req_addr);
      end
      sb_q.push_back(mk(32'h10));
      req_ready = 1'b0;
      halt      = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (req_valid !== 1'b1 || req_addr !== 32'h10) begin
            n_fail++; $display("FAIL stall_hold: cycle %0d got v=%b addr=%h expected 1 00000010", i + 1, req_valid, req_addr);
         end
         if (i < 3) tick();
      end
      req_ready = 1'b1;
      halt      = 1'b1;
      tick();
      n_checks++;
      if (req_valid !== 1'b0 || busy !== 1'b1) begin
         n_fail++; $display("FAIL stall_accept: got v=%b busy=%b expected 0 1", req_valid, busy);
      end
      wait_idle(20, ok);
      n_checks++;
      if (!ok || sb_q.size() != 0) begin
         n_fail++; $display("FAIL stall_drain: got idle=%0d pending=%0d expected 1 0", ok, sb_q.size());
      end
   endtask

   task automatic test_back_to_back();
      req_ready      = 1'b0;
      halt           = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h100;
      tick();
      n_checks++;
      if (req_valid !== 1'b1 || req_addr !== 32'h100) begin
         n_fail++; $display("FAIL b2b_first: got v=%b addr=%h expected 1 00000100", req_valid, req_addr);
      end
      redirect_pc = 32'h144;
      tick();
      n_checks++;
      if (req_addr !== 32'h144) begin
         n_fail++; $display("FAIL b2b_second: got %h expected 00000144", req_addr);
      end
      redirect_pc = 32'h181;
      tick();
      n_checks++;
      if (req_valid !== 1'b1 || req_addr !== 32'h180) begin
         n_fail++; $display("FAIL b2b_last: got v=%b addr=%h expected 1 00000180", req_valid, req_addr);
      end
      redirect_valid = 1'b0;
      sb_q.push_back(mk(32'h180));
      halt      = 1'b1;
      req_ready = 1'b1;
      tick();
      wait_idle(20, ok);
      n_checks++;
      if (!ok || sb_q.size() != 0) begin
         n_fail++; $display("FAIL b2b_drain: got idle=%0d pending=%0d expected 1 0", ok, sb_q.size());
      end
   endtask

   task automatic test_redirect_wait();
      redirect_idle(32'h8);
      lat = 3;
      sb_q.push_back(mk(32'h200));
      halt = 1'b0;
      tick();
      n_checks++;
      if (req_valid !== 1'b1 || req_addr !== 32'h8) begin
         n_fail++; $display("FAIL rw_req: got v=%b addr=%h expected 1 00000008", req_valid, req_addr);
      end
      tick();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h203;
      tick();
      redirect_valid = 1'b0;
      n_checks++;
      if (req_valid !== 1'b0 || busy !== 1'b1) begin
         n_fail++; $display("FAIL rw_still_wait: got v=%b busy=%b expected 0 1", req_valid, busy);
      end
      bad = 1'b0;
      ok  = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (inst_valid) bad = 1'b1;
         if (req_valid) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      n_checks++;
      if (bad || !ok || req_addr !== 32'h200) begin
         n_fail++; $display("FAIL rw_refetch: got inst_seen=%0d found=%0d addr=%h expected 0 1 00000200", bad, ok, req_addr);
      end
      lat  = 1;
      halt = 1'b1;
      tick();
      wait_idle(20, ok);
      n_checks++;
      if (!ok || sb_q.size() != 0) begin
         n_fail++; $display("FAIL rw_drain: got idle=%0d pending=%0d expected 1 0", ok, sb_q.size());
      end
   endtask

   task automatic test_redirect_hold();
      redirect_idle(32'h30);
      inst_ready = 1'b0;
      sb_q.push_back(mk(32'h400));
      halt = 1'b0;
      tick(); tick(); tick();
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (inst_valid !== 1'b1 || inst_pc !== 32'h30 || inst_data !== imem_word(32'h30)) begin
            n_fail++; $display("FAIL rh_hold: cycle %0d got v=%b pc=%h data=%h expected 1 00000030 %h",
                               i, inst_valid, inst_pc, inst_data, imem_word(32'h30));
         end
         if (i == 0) tick();
      end
      redirect_valid = 1'b1;
      redirect_pc    = 32'h400;
      tick();
      redirect_valid = 1'b0;
      n_checks++;
      if (inst_valid !== 1'b0 || req_valid !== 1'b1 || req_addr !== 32'h400) begin
         n_fail++; $display("FAIL rh_redirect: got iv=%b rv=%b addr=%h expected 0 1 00000400", inst_valid, req_valid, req_addr);
      end
      inst_ready = 1'b1;
      halt       = 1'b1;
      tick();
      wait_idle(20, ok);
      n_checks++;
      if (!ok || sb_q.size() != 0) begin
         n_fail++; $display("FAIL rh_drain: got idle=%0d pending=%0d expected 1 0", ok, sb_q.size());
      end
   endtask

   task automatic test_redirect_accept();
      redirect_idle(32'h20);
      lat = 2;
      sb_q.push_back(mk(32'h80));
      halt = 1'b0;
      tick();
      n_checks++;
      if (req_valid !== 1'b1 || req_addr !== 32'h20) begin
         n_fail++; $display("FAIL ra_req: got v=%b addr=%h expected 1 00000020", req_valid, req_addr);
      end
      redirect_valid = 1'b1;
      redirect_pc    = 32'h80;
      tick();
      redirect_valid = 1'b0;
      n_checks++;
      if (req_valid !== 1'b0 || busy !== 1'b1 || inst_valid !== 1'b0) begin
         n_fail++; $display("FAIL ra_wait: got rv=%b busy=%b iv=%b expected 0 1 0", req_valid, busy, inst_valid);
      end
      bad = 1'b0;
      ok  = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (inst_valid) bad = 1'b1;
         if (req_valid) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      n_checks++;
      if (bad || !ok || req_addr !== 32'h80) begin
         n_fail++; $display("FAIL ra_refetch: got inst_seen=%0d found=%0d addr=%h expected 0 1 00000080", bad, ok, req_addr);
      end
      lat  = 1;
      halt = 1'b1;
      tick();
      wait_idle(20, ok);
      n_checks++;
      if (!ok || sb_q.size() != 0) begin
         n_fail++; $display("FAIL ra_drain: got idle=%0d pending=%0d expected 1 0", ok, sb_q.size());
      end
   endtask

   task automatic test_timeout();
      redirect_idle(32'h50);
      lat = 7;
      sb_q.push_back(mk(32'h50));
      n_checks++;
      if (fetch_err !== 1'b0) begin
         n_fail++; $display("FAIL to_pre: got fetch_err=%b expected 0", fetch_err);
      end
      halt = 1'b0;
      tick();
      tick();
      halt = 1'b1;
      tick(); tick(); tick();
      n_checks++;
      if (fetch_err !== 1'b0) begin
         n_fail++; $display("FAIL to_early: got fetch_err=%b after 3 wait cycles expected 0", fetch_err);
      end
      tick();
      n_checks++;
      if (fetch_err !== 1'b1 || busy !== 1'b1 || inst_valid !== 1'b0 || req_valid !== 1'b0) begin
         n_fail++; $display("FAIL to_set: got err=%b busy=%b iv=%b rv=%b expected 1 1 0 0", fetch_err, busy, inst_valid, req_valid);
      end
      wait_idle(20, ok);
      n_checks++;
      if (!ok || sb_q.size() != 0 || fetch_err !== 1'b1) begin
         n_fail++; $display("FAIL to_late_rsp: got idle=%0d pending=%0d err=%b expected 1 0 1", ok, sb_q.size(), fetch_err);
      end
      lat = 1;
   endtask

   task automatic test_wrap();
      redirect_idle(32'hFFFF_FFFF);
      sb_q.push_back(mk(32'hFFFF_FFFC));
      sb_q.push_back(mk(32'h0));
      halt = 1'b0;
      wait_req(10, ok);
      n_checks++;
      if (!ok || req_addr !== 32'hFFFF_FFFC) begin
         n_fail++; $display("FAIL wrap_first: got found=%0d addr=%h expected 1 fffffffc", ok, req_addr);
      end
      tick();
      wait_req(10, ok);
      n_checks++;
      if (!ok || req_addr !== 32'h0) begin
         n_fail++; $display("FAIL wrap_next: got found=%0d addr=%h expected 1 00000000", ok, req_addr);
      end
      halt = 1'b1;
      tick();
      wait_idle(20, ok);
      n_checks++;
      if (!ok || sb_q.size() != 0 || fetch_err !== 1'b1) begin
         n_fail++; $display("FAIL wrap_drain: got idle=%0d pending=%0d err=%b expected 1 0 1", ok, sb_q.size(), fetch_err);
      end
   endtask

   task automatic test_reset_midflight();
      redirect_idle(32'h60);
      halt = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      #1;
      n_checks++;
      if ({fetch_err, busy, req_valid, inst_valid} !== 4'b0000 || req_addr !== 32'h0) begin
         n_fail++; $display("FAIL rst_async: got err=%b busy=%b rv=%b iv=%b addr=%h expected 0 0 0 0 00000000",
                            fetch_err, busy, req_valid, inst_valid, req_addr);
      end
      halt = 1'b1;
      tick(); tick();
      rst = 1'b1;
      tick(); tick();
      n_checks++;
      if (busy !== 1'b0 || inst_valid !== 1'b0 || fetch_err !== 1'b0 || sb_q.size() != 0) begin
         n_fail++; $display("FAIL rst_after: got busy=%b iv=%b err=%b pending=%0d expected 0 0 0 0",
                            busy, inst_valid, fetch_err, sb_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_req_stall();
      test_back_to_back();
      test_redirect_wait();
      test_redirect_hold();
      test_redirect_accept();
      test_timeout();
      test_wrap();
      test_reset_midflight();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
